// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  // op_sel encodings from the main control unit
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_sel_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10
  } state_e;

  // Which unit owns the operation in flight
  typedef enum logic {
    UNIT_MUL = 1'b0,
    UNIT_DIV = 1'b1
  } unit_e;

  // Default watchdog limit in WAIT cycles
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Divisor check done before the divider is ever started
  function automatic logic is_zero32(input logic [31:0] v);
    return (v == 32'd0);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: WAIT-cycle down-counter that flags expiry of an in-flight op.
// Only instantiated when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Load the limit on launch, then count down one per WAIT cycle without done
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(TIMEOUT);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // The last counted cycle is the one that would take the count to zero
  assign expire_o = dec_i && (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: launches the multiply/divide units, owns HI/LO and stalls HI/LO
// access while an operation is in flight. Optional watchdog abort is enabled by
// defining MULDIV_TIMEOUT_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
`ifdef MULDIV_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        rd_req,
  output logic        mul_start,
  output logic        div_start,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        op_done,
  output logic        div_zero,
  output logic        timeout_err
);

  state_e      state_q;
  unit_e       unit_q;
  logic [31:0] op_a_q, op_b_q, hi_q, lo_q;
  logic        busy_q, mul_start_q, div_start_q, op_done_q, div_zero_q;

  op_sel_e     op_sel_s;
  logic        unit_done_s;
  logic [31:0] unit_hi_s, unit_lo_s;

  assign op_sel_s = op_sel_e'(op_sel);

  // Only the selected unit's handshake and result are ever looked at
  always_comb begin
    unit_done_s = 1'b0;
    unit_hi_s   = 32'd0;
    unit_lo_s   = 32'd0;
    if (unit_q == UNIT_DIV) begin
      unit_done_s = div_done;
      unit_hi_s   = div_hi;
      unit_lo_s   = div_lo;
    end else begin
      unit_done_s = mul_done;
      unit_hi_s   = mul_hi;
      unit_lo_s   = mul_lo;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  logic expire_s;
  logic timeout_err_q;

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .load_i   (state_q == ST_LAUNCH),
    .dec_i    ((state_q == ST_WAIT) && !unit_done_s),
    .expire_o (expire_s)
  );

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Sequencer FSM with operand latches, HI/LO and all registered strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      unit_q      <= UNIT_MUL;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      op_done_q   <= 1'b0;
      div_zero_q  <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-armed below
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      op_done_q   <= 1'b0;
      div_zero_q  <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            case (op_sel_s)
              OP_MULT: begin
                op_a_q      <= a_in;
                op_b_q      <= b_in;
                unit_q      <= UNIT_MUL;
                mul_start_q <= 1'b1;
                busy_q      <= 1'b1;
                state_q     <= ST_LAUNCH;
              end
              OP_DIV: begin
                if (is_zero32(b_in)) begin
                  // Trapped here so the divider never sees a zero divisor
                  div_zero_q <= 1'b1;
                  op_done_q  <= 1'b1;
                end else begin
                  op_a_q      <= a_in;
                  op_b_q      <= b_in;
                  unit_q      <= UNIT_DIV;
                  div_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ST_LAUNCH;
                end
              end
              OP_MTHI: begin
                hi_q      <= a_in;
                op_done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q      <= a_in;
                op_done_q <= 1'b1;
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          // The start pulse is on during this cycle; done is not looked at yet
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (unit_done_s) begin
            hi_q      <= unit_hi_s;
            lo_q      <= unit_lo_s;
            op_done_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
`ifdef MULDIV_TIMEOUT_EN
          else if (expire_s) begin
            timeout_err_q <= 1'b1;
            op_done_q     <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
`endif
          else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_start = mul_start_q;
  assign div_start = div_start_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign op_done   = op_done_q;
  assign div_zero  = div_zero_q;

  // No registered delay so an MFHI in the cycle busy falls proceeds
  assign stall = busy_q & (rd_req | op_start);

endmodule
